// File: rtl/tenyr_mem_arb_pkg.sv
// Shared definitions for the tenyr memory arbiter.
// - State encoding for the arbiter FSM.
// - ERR_WORD: value returned on a timed-out or post-error access; the core
//   decodes it as an illegal instruction and halts.
// - Halt-type bit indices for the core's halt vector.
package tenyr_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IBUS = 2'd1;
  localparam logic [1:0] ST_DBUS = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

  // Halt-type bit indices into the core's halt vector.
  localparam int HALT_EXPLICIT = 0;
  localparam int HALT_ILLEGAL  = 1;
  localparam int HALT_MEMERR   = 2;
  localparam int HALT_TYPES    = 3;

endpackage

// File: rtl/tenyr_wait_timer.sv
// Wait-cycle counter for an outstanding memory request.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : zero the counter (ack seen or arbiter state change)
//   enable       : a cycle spent waiting (m_req=1, m_ack=0)
//   expired      : this waiting cycle is the WAIT_MAX-th one
module tenyr_wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n)     count <= '0;
    else if (clear)   count <= '0;
    else if (enable)  count <= count + CW'(1);
  end

  // Fires during the WAIT_MAX-th waiting cycle so m_req is high for exactly
  // WAIT_MAX unacknowledged cycles before it drops.
  assign expired = enable & (count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/tenyr_mem_arb.sv
// Single-port memory arbiter between the tenyr core's fetch and data ports
// and a variable-latency request/ack memory.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   i_req/i_addr -> i_data/i_valid : instruction fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid : data port
//   core_stall                   : gates the core enable while a port waits
//   m_req/m_we/m_addr/m_wdata, m_ack/m_rdata : memory master port
//   err                          : sticky memory-timeout flag
module tenyr_mem_arb
  import tenyr_mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        core_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        err
);

  logic [1:0] state_q, state_d;
  logic       i_pend, d_pend;
  logic       expired;
  logic       issue_i, issue_d;   // start a memory transaction for a port
  logic       done_i, done_d;     // complete a port with m_rdata
  logic       fail_i, fail_d;     // complete a port with ERR_WORD

  // A request is not pending in its own valid cycle: the core has not yet
  // had a chance to drop or change it.
  assign i_pend = i_req & ~i_valid;
  assign d_pend = d_req & ~d_valid;

  assign core_stall = (i_req & ~i_valid) | (d_req & ~d_valid);

  tenyr_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (m_ack | (state_d != state_q)),
    .enable  (m_req & ~m_ack),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; data wins ties since it belongs to the older instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_pend)      state_d = ST_DBUS;
        else if (i_pend) state_d = ST_IBUS;
      end
      ST_IBUS: begin
        if (m_ack)        state_d = d_pend ? ST_DBUS : ST_IDLE;
        else if (expired) state_d = ST_ERR;
      end
      ST_DBUS: begin
        if (m_ack)        state_d = i_pend ? ST_IBUS : ST_IDLE;
        else if (expired) state_d = ST_ERR;
      end
      default: state_d = ST_ERR;
    endcase
  end

  // Output decode: what happens to each port this cycle.
  always_comb begin
    issue_i = 1'b0;
    issue_d = 1'b0;
    done_i  = 1'b0;
    done_d  = 1'b0;
    fail_i  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue_d = d_pend;
        issue_i = i_pend & ~d_pend;
      end
      ST_IBUS: begin
        if (m_ack) begin
          done_i  = 1'b1;
          issue_d = d_pend;
        end else if (expired) begin
          fail_i = 1'b1;
        end
      end
      ST_DBUS: begin
        if (m_ack) begin
          done_d  = 1'b1;
          issue_i = i_pend;
        end else if (expired) begin
          fail_d = 1'b1;
        end
      end
      default: begin
        // Error state answers every request locally, never touching memory.
        fail_d = d_pend;
        fail_i = i_pend & ~d_pend;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      i_valid <= done_i | fail_i;
      d_valid <= done_d | fail_d;

      if (done_i)      i_data <= m_rdata;
      else if (fail_i) i_data <= ERR_WORD;

      // Writes leave d_rdata untouched; m_we still reflects the finishing op.
      if (done_d && !m_we) d_rdata <= m_rdata;
      else if (fail_d)     d_rdata <= ERR_WORD;

      if (issue_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (issue_i) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= i_addr;
        m_wdata <= '0;
      end else if (done_i || done_d || fail_i || fail_d) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
      end

      if (state_d == ST_ERR) err <= 1'b1;
    end
  end

endmodule
